// File: rtl/oled_spi_rx.sv
// -----------------------------------------------------------------------------
// oled_spi_rx
//
// Receive-side model of the OLED SPI link. It oversamples the link in the
// sysclk domain, assembles MSB-first bytes, tags each with D/C, and queues
// them in a FIFO with a valid/ready read port. It also tracks the panel
// power sequence and flags protocol errors.
//
// Optional feature: define OLED_RX_BYTE_COUNT_EN to add the cmd_count and
// data_count push-attempt counters.
//
// Ports:
//   sysclk      system clock; all logic is on its rising edge
//   rst         synchronous active-high reset
//   oled_sclk   SPI clock (idle low, data taken on its rising edge)
//   oled_sdin   SPI data, MSB first
//   oled_dc     0 = command, 1 = data; taken with the 8th bit
//   oled_res    panel reset, active low
//   oled_vdd    logic supply enable, active low
//   oled_vbat   panel supply enable, active low
//   rx_data     head-of-FIFO byte (0 when empty)
//   rx_dc       D/C tag of rx_data
//   rx_valid    FIFO non-empty
//   rx_ready    consumer accepts rx_data on rx_valid & rx_ready
//   overflow    sticky: a byte was dropped because the FIFO was full
//   frame_err   sticky: a partial byte was discarded
//   err_clr     clears overflow and frame_err (and the byte counters)
//   pwr_state   0 OFF, 1 VDD_ON, 2 ACTIVE, 3 SEQ_ERR
//   level       FIFO occupancy
//   cmd_count   (optional) command bytes seen, saturating
//   data_count  (optional) data bytes seen, saturating
// -----------------------------------------------------------------------------
module oled_spi_rx #(
   parameter int DEPTH       = 16,
   parameter int IDLE_CYCLES = 1024,
   parameter int SYNC_STAGES = 2
) (
   input  logic                     sysclk,
   input  logic                     rst,
   input  logic                     oled_sclk,
   input  logic                     oled_sdin,
   input  logic                     oled_dc,
   input  logic                     oled_res,
   input  logic                     oled_vdd,
   input  logic                     oled_vbat,
   output logic [7:0]               rx_data,
   output logic                     rx_dc,
   output logic                     rx_valid,
   input  logic                     rx_ready,
   output logic                     overflow,
   output logic                     frame_err,
   input  logic                     err_clr,
   output logic [1:0]               pwr_state,
   output logic [$clog2(DEPTH):0]   level
`ifdef OLED_RX_BYTE_COUNT_EN
   ,
   output logic [15:0]              cmd_count,
   output logic [15:0]              data_count
`endif
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int LVL_W  = PTR_W + 1;
   localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);

   // Bit order of each synchronizer stage: {vbat, vdd, res, dc, sdin, sclk}.
   // The active-low controls reset to 1 so the panel reads as off/not-in-reset.
   localparam logic [5:0] SYNC_INIT = 6'b111000;

   typedef enum logic [1:0] {
      PWR_OFF     = 2'd0,
      PWR_VDD_ON  = 2'd1,
      PWR_ACTIVE  = 2'd2,
      PWR_SEQ_ERR = 2'd3
   } pwr_t;

   // ---------------------------------------------------------------- sync
   logic [5:0] sync_reg [SYNC_STAGES];

   always_ff @(posedge sysclk) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_reg[i] <= SYNC_INIT;
      end else begin
         sync_reg[0] <= {oled_vbat, oled_vdd, oled_res, oled_dc, oled_sdin, oled_sclk};
         for (int i = 1; i < SYNC_STAGES; i++) sync_reg[i] <= sync_reg[i-1];
      end
   end

   logic [5:0] link;
   logic       sclk_s, sdin_s, dc_s, res_s, vdd_on, vbat_on;
   assign link    = sync_reg[SYNC_STAGES-1];
   assign sclk_s  = link[0];
   assign sdin_s  = link[1];
   assign dc_s    = link[2];
   assign res_s   = link[3];
   assign vdd_on  = ~link[4];
   assign vbat_on = ~link[5];

   // Rise detection is registered together with the data/dc it qualifies,
   // so the shift engine sees a clean one-cycle pulse with aligned data.
   logic sclk_prev_reg, rise_reg, sdin_d_reg, dc_d_reg;

   always_ff @(posedge sysclk) begin
      if (rst) begin
         sclk_prev_reg <= 1'b0;
         rise_reg      <= 1'b0;
         sdin_d_reg    <= 1'b0;
         dc_d_reg      <= 1'b0;
      end else begin
         sclk_prev_reg <= sclk_s;
         rise_reg      <= sclk_s & ~sclk_prev_reg;
         sdin_d_reg    <= sdin_s;
         dc_d_reg      <= dc_s;
      end
   end

   // -------------------------------------------------------- shift engine
   logic [2:0]        bit_cnt_reg, bit_cnt_next;
   logic [7:0]        shift_reg, shift_next;
   logic [IDLE_W-1:0] idle_reg, idle_next;
   logic              push, frame_set;
   logic [8:0]        push_word;

   always_comb begin
      bit_cnt_next = bit_cnt_reg;
      shift_next   = shift_reg;
      idle_next    = idle_reg;
      push         = 1'b0;
      frame_set    = 1'b0;
      push_word    = {dc_d_reg, shift_reg[6:0], sdin_d_reg};
      if (!res_s) begin
         // Panel in reset: drop any partial byte and ignore the clock.
         bit_cnt_next = 3'd0;
         idle_next    = '0;
         frame_set    = (bit_cnt_reg != 3'd0);
      end else if (rise_reg) begin
         idle_next  = '0;
         shift_next = {shift_reg[6:0], sdin_d_reg};
         if (bit_cnt_reg == 3'd7) begin
            push         = 1'b1;
            bit_cnt_next = 3'd0;
         end else begin
            bit_cnt_next = bit_cnt_reg + 3'd1;
         end
      end else if (bit_cnt_reg != 3'd0) begin
         if (idle_reg == IDLE_W'(IDLE_CYCLES - 1)) begin
            bit_cnt_next = 3'd0;
            idle_next    = '0;
            frame_set    = 1'b1;
         end else begin
            idle_next = idle_reg + IDLE_W'(1);
         end
      end
   end

   always_ff @(posedge sysclk) begin
      if (rst) begin
         bit_cnt_reg <= 3'd0;
         shift_reg   <= 8'h00;
         idle_reg    <= '0;
      end else begin
         bit_cnt_reg <= bit_cnt_next;
         shift_reg   <= shift_next;
         idle_reg    <= idle_next;
      end
   end

   // ---------------------------------------------------------------- FIFO
   logic [8:0]       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [LVL_W-1:0] count_reg;
   logic             full, empty, pop, wr_en, drop;

   assign full  = (count_reg == LVL_W'(DEPTH));
   assign empty = (count_reg == '0);
   assign pop   = ~empty & rx_ready;
   // When full, a simultaneous pop frees the slot the push lands in.
   assign wr_en = push & (~full | pop);
   assign drop  = push & full & ~pop;

   always_ff @(posedge sysclk) begin
      if (wr_en) mem[wr_ptr_reg] <= push_word;
   end

   always_ff @(posedge sysclk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (wr_en) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (pop)   rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         if (wr_en && !pop)      count_reg <= count_reg + LVL_W'(1);
         else if (!wr_en && pop) count_reg <= count_reg - LVL_W'(1);
      end
   end

   assign rx_valid = ~empty;
   assign rx_data  = empty ? 8'h00 : mem[rd_ptr_reg][7:0];
   assign rx_dc    = empty ? 1'b0  : mem[rd_ptr_reg][8];
   assign level    = count_reg;

   // --------------------------------------------------------- error flags
   logic overflow_reg, frame_err_reg;

   always_ff @(posedge sysclk) begin
      if (rst) begin
         overflow_reg  <= 1'b0;
         frame_err_reg <= 1'b0;
      end else begin
         // A new error wins over a simultaneous clear.
         overflow_reg  <= drop      | (overflow_reg  & ~err_clr);
         frame_err_reg <= frame_set | (frame_err_reg & ~err_clr);
      end
   end

   assign overflow  = overflow_reg;
   assign frame_err = frame_err_reg;

   // ----------------------------------------------------------- power FSM
   pwr_t pwr_reg, pwr_next;

   always_comb begin
      pwr_next = pwr_reg;
      case (pwr_reg)
         PWR_OFF: begin
            if (vbat_on)     pwr_next = PWR_SEQ_ERR;
            else if (vdd_on) pwr_next = PWR_VDD_ON;
         end
         PWR_VDD_ON: begin
            if (!vdd_on)      pwr_next = PWR_OFF;
            else if (vbat_on) pwr_next = PWR_ACTIVE;
         end
         PWR_ACTIVE: begin
            if (!vdd_on)       pwr_next = PWR_SEQ_ERR;
            else if (!vbat_on) pwr_next = PWR_VDD_ON;
         end
         default: begin
            if (!vdd_on && !vbat_on) pwr_next = PWR_OFF;
         end
      endcase
   end

   always_ff @(posedge sysclk) begin
      if (rst) pwr_reg <= PWR_OFF;
      else     pwr_reg <= pwr_next;
   end

   assign pwr_state = pwr_reg;

`ifdef OLED_RX_BYTE_COUNT_EN
   // ------------------------------------------------------- byte counters
   logic [15:0] cmd_count_reg, data_count_reg;

   always_ff @(posedge sysclk) begin
      if (rst || err_clr) begin
         cmd_count_reg  <= 16'h0000;
         data_count_reg <= 16'h0000;
      end else if (push) begin
         // Counts attempts, so dropped bytes are included.
         if (push_word[8]) begin
            if (data_count_reg != 16'hFFFF) data_count_reg <= data_count_reg + 16'd1;
         end else begin
            if (cmd_count_reg != 16'hFFFF) cmd_count_reg <= cmd_count_reg + 16'd1;
         end
      end
   end

   assign cmd_count  = cmd_count_reg;
   assign data_count = data_count_reg;
`endif

endmodule
